// File: rtl/dmem_pkg.sv
// Shared address map, STATUS layout and decode select type for the data-memory subsystem.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_LED    = MMIO_BASE + 32'h0000_0000;
  localparam logic [31:0] ADDR_TIMER  = MMIO_BASE + 32'h0000_0004;
  localparam logic [31:0] ADDR_TXDATA = MMIO_BASE + 32'h0000_0008;
  localparam logic [31:0] ADDR_STATUS = MMIO_BASE + 32'h0000_000C;

  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_TIMER,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

  // Byte address to word address; the two byte-offset bits are don't-care.
  function automatic logic [29:0] word_addr(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// M-stage load/store bus plus the TX byte stream, bundled for the data-memory subsystem.
interface dmem_mmio_if;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport slave (
    input  memwriteM, aluoutM, writedataM, tx_ready,
    output readdataM, tx_valid, tx_data
  );

  modport master (
    output memwriteM, aluoutM, writedataM, tx_ready,
    input  readdataM, tx_valid, tx_data
  );
endinterface

// File: rtl/tx_fifo.sv
// Byte FIFO with explicit occupancy count; push and pop may coincide, even when full.
module tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  output logic                   full,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A pop frees the slot the coincident push needs, so full only blocks a lone push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (LED, cycle timer, TX FIFO data/status) on the core's M stage.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  dmem_mmio_if.slave  bus,
  output logic [15:0] led
);
  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx_c;
  sel_e              sel_c;

  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic        ovf_q, ovf_d;

  logic             push_c, pop_c, drop_c;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       cnt_sat_c;
  logic [31:0]      status_c;
  logic             unused_byte_off;

  assign unused_byte_off = ^bus.aluoutM[1:0];
  assign ram_idx_c       = bus.aluoutM[RAM_AW+1:2];

  // Address decode: RAM occupies the bottom of the map, MMIO registers sit at the top.
  always_comb begin
    sel_c = SEL_NONE;
    if (bus.aluoutM[31:RAM_AW+2] == '0) begin
      sel_c = SEL_RAM;
    end else if (word_addr(bus.aluoutM) == word_addr(ADDR_LED)) begin
      sel_c = SEL_LED;
    end else if (word_addr(bus.aluoutM) == word_addr(ADDR_TIMER)) begin
      sel_c = SEL_TIMER;
    end else if (word_addr(bus.aluoutM) == word_addr(ADDR_TXDATA)) begin
      sel_c = SEL_TXDATA;
    end else if (word_addr(bus.aluoutM) == word_addr(ADDR_STATUS)) begin
      sel_c = SEL_STATUS;
    end
  end

  assign push_c = bus.memwriteM && (sel_c == SEL_TXDATA);
  assign pop_c  = bus.tx_ready && !fifo_empty;
  assign drop_c = push_c && fifo_full && !pop_c;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   (bus.writedataM[7:0]),
    .full  (fifo_full),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_dout;
  assign led          = led_q;

  always_comb begin
    led_d   = led_q;
    timer_d = timer_q + 32'd1;
    ovf_d   = ovf_q;
    if (bus.memwriteM) begin
      case (sel_c)
        SEL_LED:    led_d   = bus.writedataM[15:0];
        SEL_TIMER:  timer_d = '0;
        SEL_STATUS: ovf_d   = 1'b0;
        default:    ;
      endcase
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q   <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM has no reset; a store coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (rst && bus.memwriteM && (sel_c == SEL_RAM)) begin
      ram_q[ram_idx_c] <= bus.writedataM;
    end
  end

  always_comb begin
    cnt_sat_c = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
    status_c  = '0;
    status_c[STAT_EMPTY] = fifo_empty;
    status_c[STAT_FULL]  = fifo_full;
    status_c[STAT_OVF]   = ovf_q;
    status_c[STAT_CNT_LSB +: STAT_CNT_W] = cnt_sat_c;
  end

  always_comb begin
    bus.readdataM = '0;
    case (sel_c)
      SEL_RAM:    bus.readdataM = ram_q[ram_idx_c];
      SEL_LED:    bus.readdataM = 32'(led_q);
      SEL_TIMER:  bus.readdataM = timer_q;
      SEL_STATUS: bus.readdataM = status_c;
      default:    bus.readdataM = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: load/store vector table plus timer, TX FIFO and reset sequences.
module tb_dmem_mmio;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] led;
  int          n_cmp;
  int          n_bad;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;

  dmem_mmio_if bus();

  dmem_mmio #(.RAM_WORDS(1024), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic chk, input logic [31:0] rd, input logic [15:0] l);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.chk_rd = chk; v.exp_rd = rd; v.exp_led = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.memwriteM  = we;
    bus.aluoutM    = a;
    bus.writedataM = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    drive(1'b1, ADDR_TXDATA, {24'h0, b});
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.tx_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    vecs[0]  = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         16'h0000);
    vecs[1]  = mk(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h0000);
    vecs[2]  = mk(1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h0000);
    vecs[3]  = mk(1'b0, 32'h2000_0000, 32'h0,         1'b1, 32'h0,         16'h0000);
    vecs[4]  = mk(1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         16'h0000);
    vecs[5]  = mk(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 32'h0,         16'h0000);
    vecs[6]  = mk(1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 16'h0000);
    vecs[7]  = mk(1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0,         16'h0000);
    vecs[8]  = mk(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h0000);
    vecs[9]  = mk(1'b1, 32'hFFFF_0000, 32'h0001_ABCD, 1'b1, 32'h0,         16'h0000);
    vecs[10] = mk(1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0000_ABCD, 16'hABCD);
    vecs[11] = mk(1'b0, 32'hFFFF_0002, 32'h0,         1'b1, 32'h0000_ABCD, 16'hABCD);
    vecs[12] = mk(1'b1, 32'hFFFF_0010, 32'hFFFF_FFFF, 1'b1, 32'h0,         16'hABCD);
    vecs[13] = mk(1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0,         16'hABCD);
    vecs[14] = mk(1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0000_0001, 16'hABCD);
    vecs[15] = mk(1'b0, 32'hFFFF_0008, 32'h0,         1'b1, 32'h0,         16'hABCD);
    vecs[16] = mk(1'b1, 32'hFFFF_1000, 32'h0000_0077, 1'b1, 32'h0,         16'hABCD);

    // Reset state
    step();
    step();
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    drive(1'b0, ADDR_STATUS, 32'h0);
    #1 check("rst_status", bus.readdataM, 32'h0000_0001);
    drive(1'b0, ADDR_TIMER, 32'h0);
    #1 check("rst_timer", bus.readdataM, 32'h0);
    rst = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), bus.readdataM, vecs[i].exp_rd);
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      step();
    end
    #1 check("led_after_unmapped", 32'(led), 32'h0000_ABCD);

    // Timer clear: 0 right after the store edge, then counts up one per cycle
    drive(1'b1, ADDR_TIMER, 32'h1234_5678);
    step();
    drive(1'b0, ADDR_TIMER, 32'h0);
    #1 check("timer_clr", bus.readdataM, 32'h0);
    step();
    #1 check("timer_plus1", bus.readdataM, 32'h1);
    step();
    step();
    step();
    #1 check("timer_plus4", bus.readdataM, 32'h4);
    force dut.timer_q = 32'hFFFF_FFFF;
    #1 check("timer_forced", bus.readdataM, 32'hFFFF_FFFF);
    release dut.timer_q;
    step();
    #1 check("timer_wrap", bus.readdataM, 32'h0);
    step();
    #1 check("timer_after_wrap", bus.readdataM, 32'h1);

    // Fill past capacity with the sink stalled
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push_byte(8'(i));
      if (i <= 8) exp_q.push_back(8'(i));
    end
    drive(1'b0, ADDR_STATUS, 32'h0);
    #1 check("status_full_ovf", bus.readdataM, 32'h0000_0086);
    check("stall_valid", 32'(bus.tx_valid), 32'h1);
    check("stall_data", 32'(bus.tx_data), 32'h01);
    step();
    #1 check("stall_data_hold", 32'(bus.tx_data), 32'h01);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = exp_q.pop_front();
      #1;
      check($sformatf("drain%0d_valid", i), 32'(bus.tx_valid), 32'h1);
      check($sformatf("drain%0d_data", i), 32'(bus.tx_data), 32'(exp_b));
      step();
    end
    #1 check("drained_valid", 32'(bus.tx_valid), 32'h0);
    check("status_empty_ovf", bus.readdataM, 32'h0000_0005);
    drive(1'b1, ADDR_STATUS, 32'h0);
    step();
    drive(1'b0, ADDR_STATUS, 32'h0);
    #1 check("status_ovf_clr", bus.readdataM, 32'h0000_0001);

    // Full FIFO with a coincident push and pop
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'hA0 + 8'(i));
      exp_q.push_back(8'hA0 + 8'(i));
    end
    drive(1'b0, ADDR_STATUS, 32'h0);
    #1 check("status_full", bus.readdataM, 32'h0000_0082);
    drive(1'b1, ADDR_TXDATA, 32'h0000_0055);
    bus.tx_ready = 1'b1;
    #1 check("pp_head", 32'(bus.tx_data), 32'h0000_00A0);
    exp_b = exp_q.pop_front();
    exp_q.push_back(8'h55);
    step();
    bus.tx_ready = 1'b0;
    drive(1'b0, ADDR_STATUS, 32'h0);
    #1 check("status_pp_full", bus.readdataM, 32'h0000_0082);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = exp_q.pop_front();
      #1 check($sformatf("pp_drain%0d", i), 32'(bus.tx_data), 32'(exp_b));
      step();
    end
    #1 check("pp_empty", bus.readdataM, 32'h0000_0001);

    // Reset mid-operation with queued bytes and a coincident store
    bus.tx_ready = 1'b0;
    drive(1'b1, ADDR_LED, 32'h0000_FFFF);
    step();
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    drive(1'b0, ADDR_STATUS, 32'h0);
    #1 check("pre_rst_status", bus.readdataM, 32'h0000_0030);
    check("pre_rst_led", 32'(led), 32'h0000_FFFF);
    rst = 1'b0;
    drive(1'b1, 32'h0000_0010, 32'h0);
    step();
    rst = 1'b1;
    drive(1'b0, ADDR_STATUS, 32'h0);
    #1 check("post_rst_valid", 32'(bus.tx_valid), 32'h0);
    check("post_rst_data", 32'(bus.tx_data), 32'h0);
    check("post_rst_led", 32'(led), 32'h0);
    check("post_rst_status", bus.readdataM, 32'h0000_0001);
    drive(1'b0, 32'h0000_0010, 32'h0);
    #1 check("post_rst_ram", bus.readdataM, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
